gpio: RTL and testbench

Parametrised general-purpose I/O peripheral for the memory bus, replacing the fixed 8-bit LED register in the SoC top level. It provides per-pin output data, per-pin output enable, synchronised input sampling, and atomic set/clear of output bits. It also provides per-pin rising/falling edge interrupt capture with write-1-to-clear status and a single level interrupt output. The top level decodes a 32-byte window for this block and asserts `sel_in`.

---
 rtl/gpio.sv | 202 ++++++++++++++++++++
 tb/tb_gpio.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio.sv
// ----------------------------------------------------------------------------
// gpio : parametrised general-purpose I/O peripheral on the memory bus.
//
// Provides per-pin output data, per-pin output enable, synchronised input
// sampling, atomic set/clear of output bits, and per-pin rising/falling edge
// interrupt capture with write-1-to-clear status and a level interrupt.
//
// Register map (address_in[4:2]):
//   0 DATA_OUT  rw       4 FALL_EN     rw
//   1 DIR       rw       5 IRQ_STATUS  w1c
//   2 DATA_IN   ro       6 SET         write-1 sets DATA_OUT bits, reads 0
//   3 RISE_EN   rw       7 CLEAR       write-1 clears DATA_OUT bits, reads 0
//
// Ports:
//   clk            : sole clock, rising edge
//   reset_n        : asynchronous active-low reset
//   address_in     : byte address, only [4:2] decoded
//   sel_in         : block selected this cycle
//   read_in        : read strobe (reads have no side effects; unused)
//   read_value_out : combinational read data, 0 when not selected
//   write_mask_in  : byte-lane write enables; any bit set with sel_in writes
//   write_value_in : write data
//   pins_in        : asynchronous pad inputs
//   pins_out       : pad output data (DATA_OUT)
//   pins_oe        : pad output enables (DIR)
//   irq_out        : level interrupt, high while any IRQ_STATUS bit is set
// ----------------------------------------------------------------------------
module gpio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      address_in,
  input  logic             sel_in,
  input  logic             read_in,
  output logic [31:0]      read_value_out,
  input  logic [3:0]       write_mask_in,
  input  logic [31:0]      write_value_in,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq_out
);

  localparam logic [2:0] REG_DATA_OUT = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_DATA_IN  = 3'd2;
  localparam logic [2:0] REG_RISE_EN  = 3'd3;
  localparam logic [2:0] REG_FALL_EN  = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_SET      = 3'd6;
  localparam logic [2:0] REG_CLEAR    = 3'd7;

  // Replace the lane-enabled bits of old_val with new_val.
  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] new_val,
    input logic [WIDTH-1:0] lanes
  );
    lane_merge = (old_val & ~lanes) | (new_val & lanes);
  endfunction

  // Architectural state
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] status_r;
  logic             irq_r;

  // Input synchroniser chain and one-cycle-delayed copy of its output
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;

  // Combinational helpers
  logic [2:0]       reg_idx_s;
  logic             wr_s;
  logic [WIDTH-1:0] lane_s;
  logic [WIDTH-1:0] wbits_s;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] data_out_nxt_s;
  logic [WIDTH-1:0] dir_nxt_s;
  logic [WIDTH-1:0] rise_en_nxt_s;
  logic [WIDTH-1:0] fall_en_nxt_s;
  logic [WIDTH-1:0] status_nxt_s;
  logic [WIDTH-1:0] rd_s;

  // Address bits outside [4:2], the read strobe and write data above WIDTH
  // carry no meaning for this block; fold them into a sink.
  logic unused_s;
  assign unused_s = ^{read_in, address_in[31:5], address_in[1:0], write_value_in};

  assign reg_idx_s = address_in[4:2];
  assign wr_s      = sel_in & (|write_mask_in);
  assign sync_s    = sync_r[SYNC_STAGES-1];

  // Expand byte-lane enables to a per-bit mask over the stored width.
  always_comb begin
    lane_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_s[i] = write_mask_in[i >> 3];
    end
  end

  assign wbits_s = write_value_in[WIDTH-1:0] & lane_s;

  // Edge detection on the synchronised inputs.
  assign rise_s = sync_s & ~prev_r;
  assign fall_s = ~sync_s & prev_r;

  // Register write decode and next-state computation.
  always_comb begin
    data_out_nxt_s = data_out_r;
    dir_nxt_s      = dir_r;
    rise_en_nxt_s  = rise_en_r;
    fall_en_nxt_s  = fall_en_r;
    w1c_s          = '0;
    if (wr_s) begin
      case (reg_idx_s)
        REG_DATA_OUT: data_out_nxt_s = lane_merge(data_out_r, write_value_in[WIDTH-1:0], lane_s);
        REG_DIR:      dir_nxt_s      = lane_merge(dir_r, write_value_in[WIDTH-1:0], lane_s);
        REG_RISE_EN:  rise_en_nxt_s  = lane_merge(rise_en_r, write_value_in[WIDTH-1:0], lane_s);
        REG_FALL_EN:  fall_en_nxt_s  = lane_merge(fall_en_r, write_value_in[WIDTH-1:0], lane_s);
        REG_STATUS:   w1c_s          = wbits_s;
        REG_SET:      data_out_nxt_s = data_out_r | wbits_s;
        REG_CLEAR:    data_out_nxt_s = data_out_r & ~wbits_s;
        default:      w1c_s          = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    // Events use the enables in force before this edge, so a newly set
    // enable never captures an older edge. Set wins over a same-cycle W1C.
    status_nxt_s = (status_r & ~w1c_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= '0;
      dir_r      <= '0;
      rise_en_r  <= '0;
      fall_en_r  <= '0;
      status_r   <= '0;
      irq_r      <= 1'b0;
    end else begin
      data_out_r <= data_out_nxt_s;
      dir_r      <= dir_nxt_s;
      rise_en_r  <= rise_en_nxt_s;
      fall_en_r  <= fall_en_nxt_s;
      status_r   <= status_nxt_s;
      irq_r      <= |status_nxt_s;
    end
  end

  // Input synchroniser chain and delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= pins_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      prev_r <= sync_s;
    end
  end

  // Read mux; zero when unselected so several blocks can OR onto one bus.
  always_comb begin
    rd_s = '0;
    if (sel_in) begin
      case (reg_idx_s)
        REG_DATA_OUT: rd_s = data_out_r;
        REG_DIR:      rd_s = dir_r;
        REG_DATA_IN:  rd_s = sync_s;
        REG_RISE_EN:  rd_s = rise_en_r;
        REG_FALL_EN:  rd_s = fall_en_r;
        REG_STATUS:   rd_s = status_r;
        REG_SET:      rd_s = '0;
        REG_CLEAR:    rd_s = '0;
        default:      rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
    read_value_out             = 32'd0;
    read_value_out[WIDTH-1:0]  = rd_s;
  end

  assign pins_out = data_out_r;
  assign pins_oe  = dir_r;
  assign irq_out  = irq_r;

endmodule

// File: tb/tb_gpio.sv
// ----------------------------------------------------------------------------
// tb_gpio : self-checking bench for gpio (WIDTH=8, SYNC_STAGES=2).
// A behavioural model tracks the register file and pin history; a negedge
// process compares every DUT output with it each cycle. Directed scenarios
// add literal expectations, then a randomized phase exercises the rest.
// ----------------------------------------------------------------------------
module tb_gpio;
  localparam int W = 8;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address_in = 32'd0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = 4'd0;
  logic [31:0] write_value_in = 32'd0;
  logic [W-1:0] pins_in = '0;
  logic [W-1:0] pins_out;
  logic [W-1:0] pins_oe;
  logic        irq_out;

  always #5 clk = ~clk;

  gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .read_value_out(read_value_out),
    .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe), .irq_out(irq_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_dout = 8'h00, m_dir = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
  logic [7:0] m_stat = 8'h00, m_prev = 8'h00;
  logic [7:0] m_hist[$];   // last S pin samples; [0] is what DATA_IN shows

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 4; k++) if (m[k]) r = r | (32'hFF << (8 * k));
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic sel, input logic [2:0] idx);
    logic [7:0] v;
    if (!sel) return 32'd0;
    case (idx)
      3'd0: v = m_dout;
      3'd1: v = m_dir;
      3'd2: v = m_hist[0];
      3'd3: v = m_rise;
      3'd4: v = m_fall;
      3'd5: v = m_stat;
      default: v = 8'h00;
    endcase
    return {24'd0, v};
  endfunction

  initial begin
    for (int i = 0; i < S; i++) m_hist.push_back(8'h00);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_dout = 8'h00; m_dir = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
        m_stat = 8'h00; m_prev = 8'h00;
        for (int i = 0; i < S; i++) m_hist[i] = 8'h00;
      end else begin
        logic [7:0] syn, rise, fall, d, clr;
        syn  = m_hist[0];
        rise = syn & ~m_prev;
        fall = ~syn & m_prev;
        d    = write_value_in[7:0] & lanes(write_mask_in)[7:0];
        clr  = 8'h00;
        if (sel_in && write_mask_in != 4'd0 && address_in[4:2] == 3'd5) clr = d;
        m_stat = (m_stat & ~clr) | (rise & m_rise) | (fall & m_fall);
        if (sel_in && write_mask_in != 4'd0) begin
          case (address_in[4:2])
            3'd0: m_dout = (m_dout & ~lanes(write_mask_in)[7:0]) | d;
            3'd1: m_dir  = (m_dir  & ~lanes(write_mask_in)[7:0]) | d;
            3'd3: m_rise = (m_rise & ~lanes(write_mask_in)[7:0]) | d;
            3'd4: m_fall = (m_fall & ~lanes(write_mask_in)[7:0]) | d;
            3'd6: m_dout = m_dout | d;
            3'd7: m_dout = m_dout & ~d;
            default: ;
          endcase
        end
        m_prev = syn;
        m_hist.push_back(pins_in);
        void'(m_hist.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("pins_out", {24'd0, pins_out}, {24'd0, m_dout});
      check_eq("pins_oe",  {24'd0, pins_oe},  {24'd0, m_dir});
      check_eq("irq_out",  {31'd0, irq_out},  {31'd0, (m_stat != 8'h00)});
      check_eq("read_value", read_value_out, m_read(sel_in, address_in[4:2]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] mask);
    sel_in = 1'b1; address_in = {27'd0, idx, 2'b00};
    write_mask_in = mask; write_value_in = data;
    tick();
    sel_in = 1'b0; write_mask_in = 4'd0;
  endtask

  task automatic rd(input string name, input logic [2:0] idx, input logic [31:0] exp);
    sel_in = 1'b1; address_in = {27'd0, idx, 2'b00}; write_mask_in = 4'd0;
    #1;
    check_eq(name, read_value_out, exp);
    sel_in = 1'b0;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Reset asserted mid-cycle after outputs were driven
    wr(3'd0, 32'hFF, 4'hF);
    wr(3'd1, 32'hFF, 4'hF);
    check_eq("pre_reset_pins_out", {24'd0, pins_out}, 32'h000000FF);
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_pins_out", {24'd0, pins_out}, 32'h0);
    check_eq("reset_pins_oe",  {24'd0, pins_oe},  32'h0);
    check_eq("reset_irq",      {31'd0, irq_out},  32'h0);
    #2 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) rd("reset_reg", 3'(i), 32'h0);

    // Byte lanes and width
    wr(3'd0, 32'hDEADBEEF, 4'b0001);
    rd("lane0", 3'd0, 32'h000000EF);
    wr(3'd0, 32'hDEADBEEF, 4'b0010);
    rd("lane1_discard", 3'd0, 32'h000000EF);

    // Atomic set / clear
    wr(3'd0, 32'h0F, 4'hF);
    wr(3'd6, 32'hA0, 4'hF);
    rd("set", 3'd0, 32'h000000AF);
    wr(3'd7, 32'h03, 4'hF);
    rd("clear", 3'd0, 32'h000000AC);
    check_eq("clear_pins_out", {24'd0, pins_out}, 32'h000000AC);
    rd("set_reads0", 3'd6, 32'h0);
    rd("clear_reads0", 3'd7, 32'h0);

    // Read gating
    for (int i = 0; i < 8; i++) begin
      sel_in = 1'b0; address_in = {27'd0, 3'(i), 2'b00};
      #1 check_eq("read_gated", read_value_out, 32'h0);
    end

    // Input synchroniser latency
    pins_in = 8'h5A;
    tick();
    rd("sync_e", 3'd2, 32'h00);
    tick();
    rd("sync_e1", 3'd2, 32'h5A);

    // Edge interrupt
    pins_in = 8'h80;
    repeat (3) tick();
    wr(3'd3, 32'h01, 4'hF);
    wr(3'd4, 32'h80, 4'hF);
    pins_in = 8'h01;
    tick(); tick();
    check_eq("irq_early", {31'd0, irq_out}, 32'h0);
    tick();
    check_eq("irq_rise", {31'd0, irq_out}, 32'h1);
    rd("status_81", 3'd5, 32'h81);
    wr(3'd5, 32'h01, 4'b0001);
    rd("status_80", 3'd5, 32'h80);
    check_eq("irq_still", {31'd0, irq_out}, 32'h1);
    wr(3'd5, 32'h80, 4'b0001);
    check_eq("irq_cleared", {31'd0, irq_out}, 32'h0);

    // Set wins over same-cycle W1C
    pins_in = 8'h00;
    repeat (3) tick();
    rd("status_idle", 3'd5, 32'h00);
    pins_in = 8'h01;
    tick(); tick();
    wr(3'd5, 32'h01, 4'b0001);
    rd("collision", 3'd5, 32'h01);
    check_eq("collision_irq", {31'd0, irq_out}, 32'h1);
    wr(3'd5, 32'hFF, 4'hF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) pins_in = W'($urandom);
      sel_in         = ($urandom_range(0, 2) != 0);
      address_in     = $urandom;
      write_mask_in  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      write_value_in = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick();
    end
    sel_in = 1'b0; write_mask_in = 4'd0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
